// File: rtl/mem_wait_responder.sv
// mem_wait_responder: slow-memory stand-in answering oe/we strobes with programmable wait states and a one-cycle rdy
//   clk           rising-edge system clock
//   reset         asynchronous active-low reset; clears FSM, outputs and the whole word array
//   oe / we       read / write strobes from the controller
//   addr / wdata  word address and write data, captured when a request is accepted
//   rdata         registered read data, loaded on the edge entering ACK and held afterwards
//   rdy           one-cycle access-complete pulse
//   err           sticky flag: oe and we sampled high together while idle
//   present_state FSM state (IDLE=0, WAIT=1, ACK=2, RECOVER=3)
module mem_wait_responder #(
    parameter int ADDR_W      = 4,
    parameter int DATA_W      = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              oe,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              rdy,
    output logic              err,
    output logic [1:0]        present_state
);
    typedef enum logic [1:0] {IDLE, WAIT, ACK, RECOVER} state_t;
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [3:0] LAST = 4'(WAIT_CYCLES == 0 ? 0 : WAIT_CYCLES - 1);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rd_q, rd_d;
    logic              rdy_q, rdy_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rd_d    = rd_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        mem_d   = mem_q;
        case (state_q)
            IDLE: begin
                if (oe && we) begin
                    err_d = 1'b1;
                end else if (oe || we) begin
                    addr_d  = addr;
                    wdata_d = wdata;
                    rd_d    = oe;
                    cnt_d   = '0;
                    state_d = WAIT_CYCLES == 0 ? ACK : WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q + 4'd1;
                // abort takes priority: a dropped strobe cancels even on the last wait cycle
                if (rd_q ? !oe : !we) state_d = IDLE;
                else if (cnt_q == LAST) state_d = ACK;
            end
            ACK:     state_d = (oe || we) ? RECOVER : IDLE;
            default: state_d = (oe || we) ? RECOVER : IDLE;
        endcase
        // ACK is only ever entered from IDLE or WAIT, so this is the entry edge;
        // the _d copies already hold the live addr/wdata when WAIT_CYCLES=0
        rdy_d = state_d == ACK;
        if (rdy_d) begin
            if (rd_d) rdata_d = mem_q[addr_d];
            else mem_d[addr_d] = wdata_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_q    <= 1'b0;
            rdata_q <= '0;
            rdy_q   <= 1'b0;
            err_q   <= 1'b0;
            mem_q   <= '{default: '0};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
            rdata_q <= rdata_d;
            rdy_q   <= rdy_d;
            err_q   <= err_d;
            mem_q   <= mem_d;
        end
    end

    assign rdata         = rdata_q;
    assign rdy           = rdy_q;
    assign err           = err_q;
    assign present_state = state_q;
endmodule

// File: tb/tb_mem_wait_responder.sv
// tb_mem_wait_responder: directed bench for mem_wait_responder (WAIT_CYCLES=2 and WAIT_CYCLES=0 instances)
module tb_mem_wait_responder;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       oe = 1'b0, we = 1'b0, oe0 = 1'b0, we0 = 1'b0;
    logic [3:0] addr = '0;
    logic [7:0] wdata = '0;
    logic [7:0] rdata, rdata0;
    logic       rdy, err, rdy0, err0;
    logic [1:0] st, st0;
    int         passed = 0;
    int         total = 0;

    mem_wait_responder #(.ADDR_W(4), .DATA_W(8), .WAIT_CYCLES(2)) dut (
        .clk(clk), .reset(reset), .oe(oe), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata), .rdy(rdy), .err(err), .present_state(st)
    );

    mem_wait_responder #(.ADDR_W(4), .DATA_W(8), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .oe(oe0), .we(we0), .addr(addr), .wdata(wdata),
        .rdata(rdata0), .rdy(rdy0), .err(err0), .present_state(st0)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // issue a read on the WAIT_CYCLES=2 instance and capture rdata/rdy in the ACK cycle
    task automatic read2(input logic [3:0] a, output logic [7:0] d, output logic r);
        oe = 1'b1;
        addr = a;
        tick();
        tick();
        tick();
        d = rdata;
        r = rdy;
        oe = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        oe = 1'b1;
        we = 1'b1;
        #3;
        total++; if (st !== 2'd0) $display("FAIL reset_state got %0d want 0", st); else passed++;
        total++; if (rdy !== 1'b0) $display("FAIL reset_rdy got %b want 0", rdy); else passed++;
        tick();
        tick();
        total++; if (err !== 1'b0) $display("FAIL reset_err got %b want 0", err); else passed++;
        total++; if (rdata !== 8'h00) $display("FAIL reset_rdata got %h want 00", rdata); else passed++;
        oe = 1'b0;
        we = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        total++; if (st !== 2'd0 || err !== 1'b0) $display("FAIL release_state got st=%0d err=%b want 0/0", st, err); else passed++;
    endtask

    task automatic test_write_read();
        logic [7:0] d;
        logic       r;
        we = 1'b1;
        addr = 4'd5;
        wdata = 8'hA7;
        tick();
        total++; if (st !== 2'd1 || rdy !== 1'b0) $display("FAIL wr_e0 got st=%0d rdy=%b want 1/0", st, rdy); else passed++;
        addr = 4'd0;
        wdata = 8'h11;
        tick();
        total++; if (rdy !== 1'b0) $display("FAIL wr_e1_rdy got %b want 0", rdy); else passed++;
        tick();
        total++; if (rdy !== 1'b1 || st !== 2'd2) $display("FAIL wr_ack got rdy=%b st=%0d want 1/2", rdy, st); else passed++;
        we = 1'b0;
        tick();
        total++; if (rdy !== 1'b0 || st !== 2'd0) $display("FAIL wr_done got rdy=%b st=%0d want 0/0", rdy, st); else passed++;
        read2(4'd5, d, r);
        total++; if (d !== 8'hA7 || r !== 1'b1) $display("FAIL rd5 got rdata=%h rdy=%b want a7/1", d, r); else passed++;
        read2(4'd6, d, r);
        total++; if (d !== 8'h00 || r !== 1'b1) $display("FAIL rd6 got rdata=%h rdy=%b want 00/1", d, r); else passed++;
        total++; if (rdata !== 8'h00 || rdy !== 1'b0) $display("FAIL rd6_hold got rdata=%h rdy=%b want 00/0", rdata, rdy); else passed++;
    endtask

    task automatic test_held();
        int pulses = 0;
        oe = 1'b1;
        addr = 4'd5;
        for (int i = 0; i < 13; i++) begin
            tick();
            if (rdy === 1'b1) pulses++;
        end
        total++; if (pulses !== 1) $display("FAIL held_pulses got %0d want 1", pulses); else passed++;
        total++; if (st !== 2'd3) $display("FAIL held_state got %0d want 3", st); else passed++;
        total++; if (rdata !== 8'hA7) $display("FAIL held_rdata got %h want a7", rdata); else passed++;
        oe = 1'b0;
        tick();
        total++; if (st !== 2'd0) $display("FAIL held_release got %0d want 0", st); else passed++;
    endtask

    task automatic test_abort();
        logic [7:0] d;
        logic       r;
        int pulses = 0;
        we = 1'b1;
        addr = 4'd3;
        wdata = 8'h55;
        tick();
        we = 1'b0;
        tick();
        total++; if (st !== 2'd0) $display("FAIL abort_state got %0d want 0", st); else passed++;
        for (int i = 0; i < 4; i++) begin
            if (rdy === 1'b1) pulses++;
            tick();
        end
        total++; if (pulses !== 0) $display("FAIL abort_rdy got %0d pulses want 0", pulses); else passed++;
        read2(4'd3, d, r);
        total++; if (d !== 8'h00 || r !== 1'b1) $display("FAIL abort_rd3 got rdata=%h rdy=%b want 00/1", d, r); else passed++;
    endtask

    task automatic test_conflict();
        logic [7:0] d;
        logic       r;
        oe = 1'b1;
        we = 1'b1;
        addr = 4'd5;
        tick();
        total++; if (err !== 1'b1 || st !== 2'd0 || rdy !== 1'b0) $display("FAIL conflict got err=%b st=%0d rdy=%b want 1/0/0", err, st, rdy); else passed++;
        oe = 1'b0;
        we = 1'b0;
        tick();
        total++; if (st !== 2'd0 || rdy !== 1'b0) $display("FAIL conflict_idle got st=%0d rdy=%b want 0/0", st, rdy); else passed++;
        read2(4'd5, d, r);
        total++; if (d !== 8'hA7 || r !== 1'b1) $display("FAIL conflict_rd got rdata=%h rdy=%b want a7/1", d, r); else passed++;
        total++; if (err !== 1'b1) $display("FAIL err_sticky got %b want 1", err); else passed++;
    endtask

    task automatic test_zero_wait();
        we0 = 1'b1;
        addr = 4'd9;
        wdata = 8'h3C;
        tick();
        total++; if (rdy0 !== 1'b1 || st0 !== 2'd2) $display("FAIL zw_wr got rdy=%b st=%0d want 1/2", rdy0, st0); else passed++;
        we0 = 1'b0;
        tick();
        total++; if (rdy0 !== 1'b0 || st0 !== 2'd0) $display("FAIL zw_wr_done got rdy=%b st=%0d want 0/0", rdy0, st0); else passed++;
        oe0 = 1'b1;
        tick();
        total++; if (rdy0 !== 1'b1 || rdata0 !== 8'h3C) $display("FAIL zw_rd got rdy=%b rdata=%h want 1/3c", rdy0, rdata0); else passed++;
        oe0 = 1'b0;
        tick();
        total++; if (rdy0 !== 1'b0 || rdata0 !== 8'h3C) $display("FAIL zw_rd_hold got rdy=%b rdata=%h want 0/3c", rdy0, rdata0); else passed++;
    endtask

    task automatic test_reset_mid();
        logic [7:0] d;
        logic       r;
        int pulses = 0;
        we = 1'b1;
        addr = 4'd2;
        wdata = 8'hFF;
        tick();
        reset = 1'b0;
        #2;
        total++; if (st !== 2'd0 || rdy !== 1'b0) $display("FAIL rst_mid got st=%0d rdy=%b want 0/0", st, rdy); else passed++;
        total++; if (err !== 1'b0) $display("FAIL rst_mid_err got %b want 0", err); else passed++;
        we = 1'b0;
        tick();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (rdy === 1'b1) pulses++;
        end
        total++; if (pulses !== 0) $display("FAIL rst_mid_rdy got %0d pulses want 0", pulses); else passed++;
        read2(4'd2, d, r);
        total++; if (d !== 8'h00 || r !== 1'b1) $display("FAIL rst_mid_rd2 got rdata=%h rdy=%b want 00/1", d, r); else passed++;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_held();
        test_abort();
        test_conflict();
        test_zero_wait();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1);
    end
endmodule
